// File: rtl/expr_recognizer.sv
// Byte-serial recognizer/evaluator for digit (op digit)* expressions.
// '*' binds tighter than '+'; arithmetic wraps modulo 2^WIDTH.
module expr_recognizer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    output logic             out,
    output logic             err,
    output logic [WIDTH-1:0] value
);

    typedef enum logic [1:0] {
        START = 2'd0,
        OPND  = 2'd1,
        OPER  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sum, sum_n;
    logic [WIDTH-1:0] term, term_n;
    logic             mul, mul_n;

    logic             is_dig;
    logic             is_add;
    logic             is_mul;
    logic [WIDTH-1:0] dw;

    assign is_dig = (in >= 8'h30) && (in <= 8'h39);
    assign is_add = (in == 8'h2B);
    assign is_mul = (in == 8'h2A);
    // Low nibble of an ASCII digit is its numeric value.
    assign dw     = WIDTH'(in[3:0]);

    // State and accumulator registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= START;
            sum   <= '0;
            term  <= '0;
            mul   <= 1'b0;
        end else begin
            state <= state_n;
            sum   <= sum_n;
            term  <= term_n;
            mul   <= mul_n;
        end
    end

    // Next-state and accumulator update for the consumed character.
    always_comb begin
        state_n = state;
        sum_n   = sum;
        term_n  = term;
        mul_n   = mul;
        unique case (state)
            START: begin
                if (is_dig) begin
                    state_n = OPND;
                    sum_n   = '0;
                    term_n  = dw;
                end else begin
                    state_n = ERR;
                end
            end
            OPND: begin
                if (is_add || is_mul) begin
                    state_n = OPER;
                    mul_n   = is_mul;
                end else begin
                    state_n = ERR;
                end
            end
            OPER: begin
                if (is_dig) begin
                    state_n = OPND;
                    if (mul) begin
                        term_n = term * dw;
                    end else begin
                        sum_n  = sum + term;
                        term_n = dw;
                    end
                end else begin
                    state_n = ERR;
                end
            end
            ERR: begin
                state_n = ERR;
            end
        endcase
    end

    assign out   = (state == OPND);
    assign err   = (state == ERR);
    assign value = out ? (sum + term) : '0;

endmodule

// File: tb/tb_expr_recognizer.sv
// Bench for expr_recognizer: directed scenarios plus random streams,
// checked against a string-level parse of everything consumed so far.
module tb_expr_recognizer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  in  = 8'h00;
    logic        out16, err16;
    logic [15:0] value16;
    logic        out4, err4;
    logic [3:0]  value4;

    int total = 0;
    int bad   = 0;

    byte unsigned hist[$];

    expr_recognizer #(.WIDTH(16)) dut (
        .clk   (clk),
        .clr   (clr),
        .in    (in),
        .out   (out16),
        .err   (err16),
        .value (value16)
    );

    expr_recognizer #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .clr   (clr),
        .in    (in),
        .out   (out4),
        .err   (err4),
        .value (value4)
    );

    always #5 clk = ~clk;

    // Reference: evaluate the consumed text as a whole.
    function automatic void model(output bit o, output bit e,
                                  output bit [31:0] v);
        bit [31:0] s;
        bit [31:0] p;
        byte unsigned c;
        bit dig;
        bit op;
        e = 1'b0;
        for (int i = 0; i < hist.size(); i++) begin
            c   = hist[i];
            dig = (c >= 8'h30) && (c <= 8'h39);
            op  = (c == 8'h2B) || (c == 8'h2A);
            if ((i % 2 == 0) ? !dig : !op) e = 1'b1;
        end
        o = !e && (hist.size() % 2 == 1);
        v = 32'd0;
        if (o) begin
            s = 32'd0;
            p = 32'(hist[0] - 8'h30);
            for (int i = 1; i + 1 < hist.size(); i += 2) begin
                if (hist[i] == 8'h2A) begin
                    p = p * 32'(hist[i+1] - 8'h30);
                end else begin
                    s = s + p;
                    p = 32'(hist[i+1] - 8'h30);
                end
            end
            v = s + p;
        end
    endfunction

    task automatic check(input string tag);
        bit        eo;
        bit        ee;
        bit [31:0] ev;
        model(eo, ee, ev);
        total++;
        assert (out16 === eo) else begin
            bad++;
            $error("FAIL %s out: got %b expected %b", tag, out16, eo);
        end
        total++;
        assert (err16 === ee) else begin
            bad++;
            $error("FAIL %s err: got %b expected %b", tag, err16, ee);
        end
        total++;
        assert (value16 === ev[15:0]) else begin
            bad++;
            $error("FAIL %s value: got %0d expected %0d",
                   tag, value16, ev[15:0]);
        end
        total++;
        assert ((out4 === eo) && (err4 === ee) && (value4 === ev[3:0]))
        else begin
            bad++;
            $error("FAIL %s w4: got %b/%b/%0d expected %b/%b/%0d",
                   tag, out4, err4, value4, eo, ee, ev[3:0]);
        end
    endtask

    task automatic do_reset(input string tag);
        clr = 1'b0;
        in  = 8'($urandom);
        @(posedge clk);
        #1;
        hist.delete();
        check(tag);
    endtask

    task automatic step(input byte unsigned c, input string tag);
        clr = 1'b1;
        in  = c;
        @(posedge clk);
        #1;
        hist.push_back(c);
        check(tag);
    endtask

    task automatic feed(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) step(s[i], tag);
    endtask

    initial begin
        int len;
        byte unsigned c;

        do_reset("reset");
        feed("1+2*3", "basic");
        step("3", "dig_dig_a");
        step("3", "dig_dig_b");
        feed("+1", "err_hold");

        do_reset("mid_reset");
        feed("1+2*3", "basic_again");

        do_reset("reset2");
        feed("2*3+4*5", "prec");

        do_reset("reset3");
        step("+", "lead_op");

        do_reset("reset4");
        feed("1+a", "bad_char");

        do_reset("reset5");
        feed("9*9", "wrap");

        do_reset("reset6");
        feed("9*9*9*9*9+8*7", "overflow");

        for (int n = 0; n < 30; n++) begin
            do_reset("rnd_reset");
            len = $urandom_range(1, 15);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 19) == 0)
                    c = 8'($urandom);
                else if (k % 2 == 0)
                    c = 8'(8'h30 + $urandom_range(0, 9));
                else
                    c = ($urandom_range(0, 1) == 0) ? 8'h2B : 8'h2A;
                step(c, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/expr_recognizer.md
Name: expr_recognizer

Overview:
- Byte-serial recognizer and evaluator for ASCII arithmetic expressions of the form digit (op digit)*.
- Operators are '+' and '*'; every operand is a single ASCII digit '0'..'9'.
- One character is consumed per clock. The block flags whether the characters consumed so far form a complete, valid expression.
- It also reports the value of that expression, with '*' taking precedence over '+'.
- It sits behind a character source (UART or keypad decoder) as a streaming syntax and value checker.

Parameters:
- WIDTH, 16, width of the value output and internal accumulators; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clr  input  1  synchronous active-low reset: clr=0 at a rising clk edge clears the block.
- in  input  8  ASCII character consumed at every rising clk edge while clr=1.
- out  output  1  1 when the sequence consumed since the last reset is a valid, complete expression.
- err  output  1  1 once the sequence has become unrecoverably invalid; stays 1 until reset.
- value  output  WIDTH  value of the expression when out=1; 0 otherwise.

Behaviour:
- Reset (clr=0 at a rising edge):
  - state=START; sum=0, term=0.
  - Outputs: out=0, err=0, value=0.
  - Reset has priority over the character on in; that character is not consumed.
- Character classes:
  - DIG: 8'h30..8'h39, digit value d = in-8'h30.
  - ADD: '+' (8'h2B).
  - MUL: '*' (8'h2A).
  - BAD: any other byte.
- Moore FSM, states START, OPND (digit just seen), OPER (operator just seen), ERR. Transitions per rising edge with clr=1:
  - START: DIG -> OPND; any other class -> ERR.
  - OPND: ADD or MUL -> OPER, recording the pending operator; DIG or BAD -> ERR (multi-digit operands are illegal).
  - OPER: DIG -> OPND; any other class -> ERR.
  - ERR: stays in ERR for every input; only reset leaves it.
- Outputs are decoded from registered state only:
  - out=1 iff state=OPND.
  - err=1 iff state=ERR.
  - value=sum+term (mod 2^WIDTH) when out=1, else 0.
  - No combinational path from in to any output.
- Latency: a character presented before a rising edge is reflected on the outputs immediately after that edge (one-cycle latency).
- Accumulator updates, all on the rising edge on which the DIG is consumed:
  - DIG in START: term<=d, sum<=0.
  - DIG in OPER with pending ADD: sum<=sum+term, term<=d.
  - DIG in OPER with pending MUL: term<=term*d (truncated to WIDTH).
  - Accumulators hold their value in every other transition.
  - On entry to ERR the accumulators may hold any value; value is forced to 0 regardless.
- A trailing operator is not an accepted expression: out=0 while in OPER; out returns to 1 when the next digit is consumed.
- Overflow wraps silently and does not set err.
- There is no end-of-expression marker: out and value are continuously valid and track the prefix consumed so far.

Test Plan:
- Reset, then "1","+","2","*","3" on consecutive edges -> out after each edge 1,0,1,0,1; err=0; final value=7.
- After the above, hold in='3' for two more edges (digit after digit) -> out=0, err=1; holding err then '+','1' keeps err=1 and out=0.
- Reset mid-stream (clr=0 for one edge), then "1","+","2","*","3" again -> identical trace to the first scenario; value=7.
- Reset, then "2","*","3","+","4","*","5" -> final out=1, value=26.
- Reset, then leading '+' -> err=1, out=0 on the first edge; also 'a' after "1+" -> err=1.
- WIDTH=4: reset, then "9","*","9" -> out=1, value=81 mod 16=1, err=0.
